// File: rtl/encrypt_frame_if.sv
// Handshake and serial-output bundle between a byte source / encryptor and
// the frame controller. The controller connects through the slave modport.
interface encrypt_frame_if;
  logic        i_en;
  logic [7:0]  i_byte;
  logic        i_byte_valid;
  logic        o_byte_ready;
  logic        o_enc_data;
  logic        o_bit_valid;
  logic        o_sof;
  logic        o_dsof;
  logic        o_eof;
  logic        o_underrun;
  logic        o_busy;
  logic [15:0] o_frame_cnt;

  modport master (
    output i_en, i_byte, i_byte_valid,
    input  o_byte_ready, o_enc_data, o_bit_valid, o_sof, o_dsof, o_eof,
           o_underrun, o_busy, o_frame_cnt
  );

  modport slave (
    input  i_en, i_byte, i_byte_valid,
    output o_byte_ready, o_enc_data, o_bit_valid, o_sof, o_dsof, o_eof,
           o_underrun, o_busy, o_frame_cnt
  );
endinterface

// File: rtl/encrypt_frame_ctrl.sv
// Frame controller feeding a serial encryptor: preamble byte, FRAME_LEN
// payload bytes (MSB first, FILL_BYTE on underrun), then GAP_BITS idle zeros.
module encrypt_frame_ctrl #(
  parameter int unsigned FRAME_LEN = 4,
  parameter logic [7:0]  PREAMBLE  = 8'hA5,
  parameter int unsigned GAP_BITS  = 5,
  parameter logic [7:0]  FILL_BYTE = 8'h00
) (
  input logic            i_clk,
  input logic            i_rst_n,
  encrypt_frame_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PRE, DATA, GAP} state_t;

  localparam logic [7:0] LAST_BYTE = 8'(FRAME_LEN - 1);
  localparam logic [7:0] LAST_GAP  = 8'(GAP_BITS - 1);

  state_t      r_state, w_state_nx;
  logic [2:0]  r_bit_cnt, w_bit_cnt_nx;
  // Counts payload bytes in DATA and gap bits in GAP.
  logic [7:0]  r_byte_cnt, w_byte_cnt_nx;
  logic [7:0]  r_sh, w_sh_nx;
  logic [15:0] r_frame_cnt, w_frame_cnt_nx;

  logic        w_last_bit;
  logic        w_last_byte;
  logic        w_ready;
  logic        w_bit_valid;
  logic [7:0]  w_load_byte;

  assign w_last_bit  = (r_bit_cnt == 3'd7);
  assign w_last_byte = (r_byte_cnt == LAST_BYTE);
  // A byte is taken on the last bit of the preamble and of every payload
  // byte except the final one, so the next byte shifts out with no bubble.
  assign w_ready     = w_last_bit &&
                       ((r_state == PRE) || ((r_state == DATA) && !w_last_byte));
  assign w_load_byte = bus.i_byte_valid ? bus.i_byte : FILL_BYTE;
  assign w_bit_valid = (r_state == PRE) || (r_state == DATA);

  // State, counters, shift register and frame count; async clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_bit_cnt   <= 3'd0;
      r_byte_cnt  <= 8'd0;
      r_sh        <= 8'd0;
      r_frame_cnt <= 16'd0;
    end else begin
      r_state     <= w_state_nx;
      r_bit_cnt   <= w_bit_cnt_nx;
      r_byte_cnt  <= w_byte_cnt_nx;
      r_sh        <= w_sh_nx;
      r_frame_cnt <= w_frame_cnt_nx;
    end
  end

  // Next-state logic: sequencing through preamble, payload and gap.
  always_comb begin
    w_state_nx     = r_state;
    w_bit_cnt_nx   = r_bit_cnt;
    w_byte_cnt_nx  = r_byte_cnt;
    w_sh_nx        = r_sh;
    w_frame_cnt_nx = r_frame_cnt;
    case (r_state)
      IDLE: begin
        // The start check only looks at valid; the byte stays for PRE's end.
        if (bus.i_en && bus.i_byte_valid) begin
          w_state_nx    = PRE;
          w_sh_nx       = PREAMBLE;
          w_bit_cnt_nx  = 3'd0;
          w_byte_cnt_nx = 8'd0;
        end
      end
      PRE: begin
        w_bit_cnt_nx = r_bit_cnt + 3'd1;
        w_sh_nx      = {r_sh[6:0], 1'b0};
        if (w_last_bit) begin
          w_state_nx    = DATA;
          w_sh_nx       = w_load_byte;
          w_byte_cnt_nx = 8'd0;
        end
      end
      DATA: begin
        w_bit_cnt_nx = r_bit_cnt + 3'd1;
        w_sh_nx      = {r_sh[6:0], 1'b0};
        if (w_last_bit) begin
          if (w_last_byte) begin
            w_state_nx     = GAP;
            w_sh_nx        = 8'd0;
            w_byte_cnt_nx  = 8'd0;
            w_frame_cnt_nx = r_frame_cnt + 16'd1;
          end else begin
            w_sh_nx       = w_load_byte;
            w_byte_cnt_nx = r_byte_cnt + 8'd1;
          end
        end
      end
      GAP: begin
        w_bit_cnt_nx = 3'd0;
        if (r_byte_cnt == LAST_GAP) begin
          w_state_nx    = IDLE;
          w_byte_cnt_nx = 8'd0;
        end else begin
          w_byte_cnt_nx = r_byte_cnt + 8'd1;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // Outputs decode registered state only, except the underrun strobe which
  // also reflects the live valid at a ready cycle.
  assign bus.o_byte_ready = w_ready;
  assign bus.o_bit_valid  = w_bit_valid;
  assign bus.o_enc_data   = w_bit_valid && r_sh[7];
  assign bus.o_sof        = (r_state == PRE) && (r_bit_cnt == 3'd0);
  assign bus.o_dsof       = (r_state == DATA) && (r_byte_cnt == 8'd0) &&
                            (r_bit_cnt == 3'd0);
  assign bus.o_eof        = (r_state == DATA) && w_last_byte && w_last_bit;
  assign bus.o_underrun   = w_ready && !bus.i_byte_valid;
  assign bus.o_busy       = (r_state != IDLE);
  assign bus.o_frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_encrypt_frame_ctrl.sv
// Directed bench for encrypt_frame_ctrl with FRAME_LEN=2, GAP_BITS=5.
// Per-cycle frame tables cover nominal and underrun frames; hand sequences
// cover back-to-back frames, reset mid-frame and frame-count wrap.
module tb_encrypt_frame_ctrl;

  logic clk;
  logic rst_n;

  encrypt_frame_if bus ();

  encrypt_frame_ctrl #(
    .FRAME_LEN(2),
    .PREAMBLE (8'hA5),
    .GAP_BITS (5),
    .FILL_BYTE(8'h00)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs packed as {ready, enc, bit_valid, sof, dsof, eof, underrun, busy}.
  typedef struct {
    logic        en;
    logic        vld;
    logic [7:0]  byt;
    logic [7:0]  exp_o;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [7:0] outs();
    return {bus.o_byte_ready, bus.o_enc_data, bus.o_bit_valid, bus.o_sof,
            bus.o_dsof, bus.o_eof, bus.o_underrun, bus.o_busy};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Timeline T0..T31 of one FRAME_LEN=2 frame with payload 3C, F0.
  // i_en is dropped at T5; valid is high again at T30/T31 to show no restart.
  task automatic build_frame(input logic ur_case, input logic [15:0] base);
    logic [7:0] pre, b0, b1;
    vec_t       v;
    logic       rdy, enc, bv, sof, dsof, eof, ur, busy;
    tbl.delete();
    pre = 8'hA5;
    b0  = 8'h3C;
    b1  = ur_case ? 8'h00 : 8'hF0;
    for (int t = 0; t <= 31; t++) begin
      v.en  = (t < 5);
      v.vld = (t <= 15) || ((t == 16) && !ur_case) || (t >= 30);
      v.byt = (t <= 8) ? 8'h3C : 8'hF0;
      enc   = 1'b0;
      bv    = (t >= 1) && (t <= 24);
      busy  = (t >= 1) && (t <= 29);
      if (t >= 1 && t <= 8)        enc = pre[8 - t];
      else if (t >= 9 && t <= 16)  enc = b0[16 - t];
      else if (t >= 17 && t <= 24) enc = b1[24 - t];
      sof   = (t == 1);
      dsof  = (t == 9);
      eof   = (t == 24);
      rdy   = (t == 8) || (t == 16);
      ur    = (t == 16) && ur_case;
      v.exp_o   = {rdy, enc, bv, sof, dsof, eof, ur, busy};
      v.exp_cnt = (t >= 25) ? base + 16'd1 : base;
      tbl.push_back(v);
    end
  endtask

  task automatic run_table(input string tag);
    foreach (tbl[i]) begin
      @(negedge clk);
      bus.i_en         = tbl[i].en;
      bus.i_byte_valid = tbl[i].vld;
      bus.i_byte       = tbl[i].byt;
      #1;
      chk($sformatf("%s_T%0d_outs", tag, i), {24'd0, outs()}, {24'd0, tbl[i].exp_o});
      chk($sformatf("%s_T%0d_cnt", tag, i), {16'd0, bus.o_frame_cnt}, {16'd0, tbl[i].exp_cnt});
    end
  endtask

  initial begin
    int          nsof, sof1, sof2, nbytes;
    logic [15:0] cnt0;

    // Reset held with start conditions present: everything must stay 0.
    rst_n            = 1'b0;
    bus.i_en         = 1'b1;
    bus.i_byte_valid = 1'b1;
    bus.i_byte       = 8'hFF;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outs", {24'd0, outs()}, 32'd0);
    chk("reset_cnt", {16'd0, bus.o_frame_cnt}, 32'd0);
    @(negedge clk);
    rst_n            = 1'b1;
    bus.i_en         = 1'b0;
    bus.i_byte_valid = 1'b0;

    // Nominal frame, then an underrun frame.
    build_frame(1'b0, 16'd0);
    run_table("nom");
    build_frame(1'b1, 16'd1);
    run_table("ur");

    // Back-to-back: second start at T31, exactly 2 bytes per frame.
    cnt0   = bus.o_frame_cnt;
    nsof   = 0;
    sof1   = -1;
    sof2   = -1;
    nbytes = 0;
    for (int t = 0; t < 70; t++) begin
      @(negedge clk);
      bus.i_en         = (t < 40);
      bus.i_byte_valid = 1'b1;
      bus.i_byte       = 8'(t);
      #1;
      if (bus.o_sof) begin
        nsof++;
        if (nsof == 1) sof1 = t;
        else if (nsof == 2) sof2 = t;
      end
      if (bus.o_byte_ready && bus.i_byte_valid) nbytes++;
    end
    chk("b2b_sof1", sof1, 1);
    chk("b2b_sof2", sof2, 31);
    chk("b2b_nsof", nsof, 2);
    chk("b2b_bytes", nbytes, 4);
    chk("b2b_cnt", {16'd0, bus.o_frame_cnt}, {16'd0, cnt0 + 16'd2});
    chk("b2b_idle", {31'd0, bus.o_busy}, 32'd0);

    // Reset asserted asynchronously in the middle of T12.
    for (int t = 0; t <= 12; t++) begin
      @(negedge clk);
      bus.i_en         = 1'b1;
      bus.i_byte_valid = 1'b1;
      bus.i_byte       = 8'h77;
    end
    #1;
    chk("pre_rst_busy", {31'd0, bus.o_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_outs", {24'd0, outs()}, 32'd0);
    chk("async_rst_cnt", {16'd0, bus.o_frame_cnt}, 32'd0);
    @(negedge clk);
    #1;
    chk("held_rst_outs", {24'd0, outs()}, 32'd0);
    rst_n            = 1'b1;
    bus.i_en         = 1'b0;
    bus.i_byte_valid = 1'b0;
    build_frame(1'b0, 16'd0);
    run_table("post_rst");

    // Wrap: preset the count to FFFF while idle, next frame gives 0000.
    force dut.r_frame_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.r_frame_cnt;
    #1;
    chk("preset_cnt", {16'd0, bus.o_frame_cnt}, 32'h0000FFFF);
    build_frame(1'b0, 16'hFFFF);
    run_table("wrap");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
